// File: rtl/mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mips_multicycle_ctrl
// Purpose  : Multi-cycle MIPS32 control FSM. Sequences fetch, decode,
//            execute, memory and write-back over several clocks per
//            instruction. It waits on a memory ready handshake, counts
//            retired instructions and traps illegal encodings and bus
//            timeouts into a sticky fault state.
// Ports    : clk, rst_n (async active-low), opcode_i/func_i (from IR),
//            zero_i (ALU flag, gated in datapath), mem_ready_i;
//            datapath enables and selects (*_o), fault_o, state_o,
//            instr_count_o.
// Revision : 1.0 - initial release
// ============================================================================
module mips_multicycle_ctrl #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode_i,
    input  logic [5:0]       func_i,
    input  logic             zero_i,
    input  logic             mem_ready_i,
    output logic             pc_write_o,
    output logic             pc_write_cond_o,
    output logic [1:0]       pc_src_o,
    output logic             ir_write_o,
    output logic             iord_o,
    output logic             mem_read_o,
    output logic             mem_write_o,
    output logic             reg_write_o,
    output logic             reg_dst_o,
    output logic             mem_to_reg_o,
    output logic             alu_src_a_o,
    output logic [1:0]       alu_src_b_o,
    output logic [3:0]       alu_op_o,
    output logic [1:0]       fault_o,
    output logic [3:0]       state_o,
    output logic [CNT_W-1:0] instr_count_o
);

    localparam logic [3:0] c_FETCH    = 4'd0;
    localparam logic [3:0] c_DECODE   = 4'd1;
    localparam logic [3:0] c_EXEC_R   = 4'd2;
    localparam logic [3:0] c_WB_R     = 4'd3;
    localparam logic [3:0] c_MEM_ADDR = 4'd4;
    localparam logic [3:0] c_MEM_RD   = 4'd5;
    localparam logic [3:0] c_WB_MEM   = 4'd6;
    localparam logic [3:0] c_MEM_WR   = 4'd7;
    localparam logic [3:0] c_BRANCH   = 4'd8;
    localparam logic [3:0] c_EXEC_I   = 4'd9;
    localparam logic [3:0] c_WB_I     = 4'd10;
    localparam logic [3:0] c_JUMP     = 4'd11;
    localparam logic [3:0] c_ERROR    = 4'd15;

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_J     = 6'b000010;

    localparam logic [3:0] c_ALU_AND = 4'b0000;
    localparam logic [3:0] c_ALU_OR  = 4'b0001;
    localparam logic [3:0] c_ALU_ADD = 4'b0010;
    localparam logic [3:0] c_ALU_SUB = 4'b0110;
    localparam logic [3:0] c_ALU_SLT = 4'b0111;

    localparam logic [1:0] c_FAULT_NONE    = 2'd0;
    localparam logic [1:0] c_FAULT_ILLEGAL = 2'd1;
    localparam logic [1:0] c_FAULT_TIMEOUT = 2'd2;

    // Wait counter value on the last permitted stall cycle.
    localparam logic [7:0]       c_WAIT_LAST = 8'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [3:0]       state_q, state_d;
    logic [7:0]       wait_q, wait_d;
    logic [1:0]       fault_q, fault_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic       w_func_ok;
    logic [3:0] w_func_alu;
    logic       w_mem_wait;
    logic       w_retire;
    logic       w_pc_write, w_pc_write_cond, w_ir_write;
    logic       w_mem_read, w_mem_write, w_reg_write;

    // The branch condition is resolved in the datapath.
    logic w_unused;
    assign w_unused = zero_i;

    // R-type function decode.
    always_comb begin
        w_func_ok  = 1'b1;
        w_func_alu = c_ALU_ADD;
        case (func_i)
            6'b100000: w_func_alu = c_ALU_ADD;
            6'b100010: w_func_alu = c_ALU_SUB;
            6'b100100: w_func_alu = c_ALU_AND;
            6'b100101: w_func_alu = c_ALU_OR;
            6'b101010: w_func_alu = c_ALU_SLT;
            default:   w_func_ok  = 1'b0;
        endcase
    end

    // Next-state, handshake wait counter, fault capture and retire.
    always_comb begin
        state_d    = state_q;
        fault_d    = fault_q;
        wait_d     = 8'd0;
        w_mem_wait = 1'b0;
        w_retire   = 1'b0;
        case (state_q)
            c_FETCH:    if (mem_ready_i) state_d = c_DECODE; else w_mem_wait = 1'b1;
            c_DECODE: begin
                case (opcode_i)
                    c_OP_RTYPE: begin
                        if (w_func_ok) begin
                            state_d = c_EXEC_R;
                        end else begin
                            state_d = c_ERROR;
                            fault_d = c_FAULT_ILLEGAL;
                        end
                    end
                    c_OP_LW, c_OP_SW: state_d = c_MEM_ADDR;
                    c_OP_BEQ:         state_d = c_BRANCH;
                    c_OP_ADDI:        state_d = c_EXEC_I;
                    c_OP_J:           state_d = c_JUMP;
                    default: begin
                        state_d = c_ERROR;
                        fault_d = c_FAULT_ILLEGAL;
                    end
                endcase
            end
            c_EXEC_R:   state_d = c_WB_R;
            c_MEM_ADDR: state_d = (opcode_i == c_OP_SW) ? c_MEM_WR : c_MEM_RD;
            c_MEM_RD:   if (mem_ready_i) state_d = c_WB_MEM; else w_mem_wait = 1'b1;
            c_MEM_WR: begin
                if (mem_ready_i) begin
                    state_d  = c_FETCH;
                    w_retire = 1'b1;
                end else begin
                    w_mem_wait = 1'b1;
                end
            end
            c_EXEC_I:   state_d = c_WB_I;
            c_WB_R, c_WB_MEM, c_BRANCH, c_WB_I, c_JUMP: begin
                state_d  = c_FETCH;
                w_retire = 1'b1;
            end
            c_ERROR:    state_d = c_ERROR;
            default: begin
                state_d = c_ERROR;
                fault_d = c_FAULT_ILLEGAL;
            end
        endcase

        // Counter is zero whenever not stalling, so it starts clean on
        // entry to every memory state.
        if (w_mem_wait) begin
            if (wait_q == c_WAIT_LAST) begin
                state_d = c_ERROR;
                fault_d = c_FAULT_TIMEOUT;
            end else begin
                wait_d = wait_q + 8'd1;
            end
        end

        count_d = w_retire ? (count_q + c_CNT_ONE) : count_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= c_FETCH;
            wait_q  <= 8'd0;
            fault_q <= c_FAULT_NONE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            fault_q <= fault_d;
            count_q <= count_d;
        end
    end

    // Moore output decode (FETCH strobes IR/PC load on the completing cycle).
    always_comb begin
        w_pc_write      = 1'b0;
        w_pc_write_cond = 1'b0;
        w_ir_write      = 1'b0;
        w_mem_read      = 1'b0;
        w_mem_write     = 1'b0;
        w_reg_write     = 1'b0;
        pc_src_o        = 2'd0;
        iord_o          = 1'b0;
        reg_dst_o       = 1'b0;
        mem_to_reg_o    = 1'b0;
        alu_src_a_o     = 1'b0;
        alu_src_b_o     = 2'd0;
        alu_op_o        = c_ALU_AND;
        case (state_q)
            c_FETCH: begin
                w_mem_read  = 1'b1;
                w_ir_write  = mem_ready_i;
                w_pc_write  = mem_ready_i;
                alu_src_b_o = 2'd1;
                alu_op_o    = c_ALU_ADD;
            end
            c_DECODE: begin
                alu_src_b_o = 2'd3;
                alu_op_o    = c_ALU_ADD;
            end
            c_EXEC_R: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = w_func_alu;
            end
            c_WB_R: begin
                w_reg_write = 1'b1;
                reg_dst_o   = 1'b1;
            end
            c_MEM_ADDR, c_EXEC_I: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'd2;
                alu_op_o    = c_ALU_ADD;
            end
            c_MEM_RD: begin
                w_mem_read = 1'b1;
                iord_o     = 1'b1;
            end
            c_WB_MEM: begin
                w_reg_write  = 1'b1;
                mem_to_reg_o = 1'b1;
            end
            c_MEM_WR: begin
                w_mem_write = 1'b1;
                iord_o      = 1'b1;
            end
            c_BRANCH: begin
                alu_src_a_o     = 1'b1;
                alu_op_o        = c_ALU_SUB;
                w_pc_write_cond = 1'b1;
                pc_src_o        = 2'd1;
            end
            c_WB_I:  w_reg_write = 1'b1;
            c_JUMP: begin
                w_pc_write = 1'b1;
                pc_src_o   = 2'd2;
            end
            default: ;
        endcase
    end

    // Enables are forced off for as long as reset is held.
    assign pc_write_o      = w_pc_write      & rst_n;
    assign pc_write_cond_o = w_pc_write_cond & rst_n;
    assign ir_write_o      = w_ir_write      & rst_n;
    assign mem_read_o      = w_mem_read      & rst_n;
    assign mem_write_o     = w_mem_write     & rst_n;
    assign reg_write_o     = w_reg_write     & rst_n;

    assign fault_o       = fault_q;
    assign state_o       = state_q;
    assign instr_count_o = count_q;

endmodule
`default_nettype wire
